// File: rtl/apb_reg_slave.sv
// APB3 responder for the 8-entry register file: decodes writes onto the file's write port and serves reads from R0..R7.
// Optional byte-strobe merging is enabled by defining APB_REG_PSTRB_EN.
module apb_reg_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_NUM        = 8,
  parameter int REG_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int REG_NUM_EFF   = (REG_NUM < 2) ? 2 : REG_NUM,
  localparam int RAW           = $clog2(REG_NUM_EFF)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
`ifdef APB_REG_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
`endif
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      reg_apb_wen,
  output logic [REG_DATA_WIDTH-1:0] reg_apb_wdata,
  output logic [RAW-1:0]            reg_apb_addr,
  input  logic [REG_DATA_WIDTH-1:0] R0,
  input  logic [REG_DATA_WIDTH-1:0] R1,
  input  logic [REG_DATA_WIDTH-1:0] R2,
  input  logic [REG_DATA_WIDTH-1:0] R3,
  input  logic [REG_DATA_WIDTH-1:0] R4,
  input  logic [REG_DATA_WIDTH-1:0] R5,
  input  logic [REG_DATA_WIDTH-1:0] R6,
  input  logic [REG_DATA_WIDTH-1:0] R7
);

  localparam int BOFF = $clog2(REG_DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] BMASK = ADDR_WIDTH'(REG_DATA_WIDTH/8 - 1);

  typedef enum logic [1:0] {IDLE, WR_ACC, RD_WAIT, RD_DONE} state_t;

  state_t                    state_q;
  logic [DATA_WIDTH-1:0]     prdata_q;
  logic                      pready_q, pslverr_q, wen_q, err_q;
  logic [REG_DATA_WIDTH-1:0] wdata_q;
  logic [RAW-1:0]            addr_q;

  logic [ADDR_WIDTH-1:0]     off, idx_full;
  logic                      err;
  logic [RAW-1:0]            idx_d;
  logic [REG_DATA_WIDTH-1:0] wdata_d;
  logic                      wen_d;
  logic [REG_DATA_WIDTH-1:0] regs [8];
  logic [2:0]                rd_sel;

  assign regs = '{R0, R1, R2, R3, R4, R5, R6, R7};

  // Decode of the address presented during the setup phase.
  assign off      = paddr - BASE_ADDR;
  assign idx_full = off >> BOFF;
  assign err      = (paddr < BASE_ADDR) || (idx_full >= ADDR_WIDTH'(REG_NUM)) || ((off & BMASK) != '0);
  assign idx_d    = idx_full[RAW-1:0];
  assign rd_sel   = 3'(addr_q);

`ifdef APB_REG_PSTRB_EN
  logic [2:0] su_sel;
  assign su_sel = 3'(idx_d);

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    wdata_d = regs[su_sel];
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (pstrb[b]) wdata_d[8*b +: 8] = pwdata[8*b +: 8];
    end
  end
  assign wen_d = !err && (pstrb != '0);
`else
  assign wdata_d = REG_DATA_WIDTH'(pwdata);
  assign wen_d   = !err;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            addr_q  <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err;
            if (pwrite) begin
              state_q   <= WR_ACC;
              pready_q  <= 1'b1;
              pslverr_q <= err;
              wen_q     <= wen_d;
            end else begin
              state_q  <= RD_WAIT;
              pready_q <= 1'b0;
            end
          end
        end
        WR_ACC: begin
          wen_q     <= 1'b0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        RD_WAIT: begin
          // A master that drops psel mid-read abandons the transfer.
          if (!psel) begin
            state_q <= IDLE;
          end else begin
            prdata_q  <= err_q ? '0 : DATA_WIDTH'(regs[rd_sel]);
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            state_q   <= RD_DONE;
          end
        end
        RD_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata        = prdata_q;
  assign pready        = pready_q;
  assign pslverr       = pslverr_q;
  assign reg_apb_wen   = wen_q;
  assign reg_apb_wdata = wdata_q;
  assign reg_apb_addr  = addr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed APB master with a register-file model; expected responses are queued at drive time and checked on pready.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata, reg_apb_wdata;
  logic        pready, pslverr, reg_apb_wen;
  logic [2:0]  reg_apb_addr;
  logic [31:0] rf [8] = '{default: 32'h0};

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        wr;
    logic        err;
    logic        wen;
    logic [2:0]  idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  apb_reg_slave #(.BASE_ADDR(32'h1000)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REG_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .reg_apb_wen(reg_apb_wen), .reg_apb_wdata(reg_apb_wdata), .reg_apb_addr(reg_apb_addr),
    .R0(rf[0]), .R1(rf[1]), .R2(rf[2]), .R3(rf[3]),
    .R4(rf[4]), .R5(rf[5]), .R6(rf[6]), .R7(rf[7])
  );

  // Register file commits at the end of the cycle in which wen is high.
  always @(posedge clk) if (reg_apb_wen) rf[reg_apb_addr] <= reg_apb_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"}, prdata, 32'h0);
    check({tag, "_pready"}, {31'b0, pready}, 32'h0);
    check({tag, "_pslverr"}, {31'b0, pslverr}, 32'h0);
    check({tag, "_wen"}, {31'b0, reg_apb_wen}, 32'h0);
    check({tag, "_wdata"}, reg_apb_wdata, 32'h0);
    check({tag, "_addr"}, {29'b0, reg_apb_addr}, 32'h0);
  endtask

  // One APB transfer. Returns at the falling edge where pready is seen, so a
  // following call places its setup right after the completion edge.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic exp_err, input logic [2:0] exp_idx, input logic [31:0] exp_val);
    exp_t e;
    int waits = 0, wens = 0;
    logic got = 1'b0;
    logic [31:0] seen_wdata = '0;
    logic [2:0]  seen_addr = '0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    sb_q.push_back('{wr: wr, err: exp_err, wen: wr && !exp_err && (strb != 4'h0),
                     idx: exp_idx, val: exp_val});
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (reg_apb_wen) begin
        wens++;
        seen_wdata = reg_apb_wdata;
        seen_addr  = reg_apb_addr;
      end
      if (pready) got = 1'b1;
      else waits++;
    end
    check({tag, "_pready_seen"}, {31'b0, got}, 32'h1);
    e = sb_q.pop_front();
    check({tag, "_waits"}, waits, e.wr ? 32'd0 : 32'd1);
    check({tag, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
    check({tag, "_wen_cycles"}, wens, e.wen ? 32'd1 : 32'd0);
    if (e.wr && e.wen) begin
      check({tag, "_wdata"}, seen_wdata, e.val);
      check({tag, "_addr"}, {29'b0, seen_addr}, {29'b0, e.idx});
    end
    if (!e.wr) check({tag, "_prdata"}, prdata, e.val);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    xfer("wr_r2", 1, 32'h1008, 32'hDEADBEEF, 4'hF, 0, 3'd2, 32'hDEADBEEF);
    xfer("rd_r2", 0, 32'h1008, 32'h0, 4'hF, 0, 3'd2, 32'hDEADBEEF);
    xfer("wr_idx8", 1, 32'h1020, 32'h55555555, 4'hF, 1, 3'd0, 32'h0);
    xfer("wr_misal", 1, 32'h1002, 32'h66666666, 4'hF, 1, 3'd0, 32'h0);
    xfer("wr_below", 1, 32'h0FFC, 32'h77777777, 4'hF, 1, 3'd0, 32'h0);
    xfer("rd_idx8", 0, 32'h1020, 32'h0, 4'hF, 1, 3'd0, 32'h0);
    xfer("wr_r5", 1, 32'h1014, 32'h00001234, 4'hF, 0, 3'd5, 32'h00001234);
    xfer("rd_r5", 0, 32'h1014, 32'h0, 4'hF, 0, 3'd5, 32'h00001234);
    xfer("wr_r0", 1, 32'h1000, 32'hA5A50001, 4'hF, 0, 3'd0, 32'hA5A50001);
    xfer("rd_r7", 0, 32'h101C, 32'h0, 4'hF, 0, 3'd7, 32'h0);
    xfer("rd_r0", 0, 32'h1000, 32'h0, 4'hF, 0, 3'd0, 32'hA5A50001);
    go_idle();

    // penable without a preceding setup must not start a transfer.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h1004; pwdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      check("noseq_pready", {31'b0, pready}, 32'h0);
      check("noseq_wen", {31'b0, reg_apb_wen}, 32'h0);
    end
    go_idle();

    // Reset while the read is in RD_WAIT.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1000;
    @(posedge clk); #1;
    penable = 1'b1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_rdwait");
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer("rd_after_rst", 0, 32'h1008, 32'h0, 4'hF, 0, 3'd2, 32'hDEADBEEF);
    go_idle();

    // Reset coinciding with a write setup.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1008; pwdata = 32'h0BADBAD0; reset = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_all_zero("rst_wrsetup");
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer("rd_r2_kept", 0, 32'h1008, 32'h0, 4'hF, 0, 3'd2, 32'hDEADBEEF);
    xfer("wr_r3", 1, 32'h100C, 32'hCAFEF00D, 4'hF, 0, 3'd3, 32'hCAFEF00D);
    xfer("rd_r3", 0, 32'h100C, 32'h0, 4'hF, 0, 3'd3, 32'hCAFEF00D);

`ifdef APB_REG_PSTRB_EN
    xfer("wr_r1_full", 1, 32'h1004, 32'h11223344, 4'hF, 0, 3'd1, 32'h11223344);
    xfer("wr_r1_strb", 1, 32'h1004, 32'hAABBCCDD, 4'b0101, 0, 3'd1, 32'h11BB33DD);
    xfer("rd_r1_strb", 0, 32'h1004, 32'h0, 4'hF, 0, 3'd1, 32'h11BB33DD);
    xfer("wr_r1_nostrb", 1, 32'h1004, 32'h99999999, 4'h0, 0, 3'd1, 32'h0);
    xfer("rd_r1_nostrb", 0, 32'h1004, 32'h0, 4'hF, 0, 3'd1, 32'h11BB33DD);
`endif
    go_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
